data_sram_responder: RTL and testbench

Memory-side responder for the CPU data port. It accepts SRAM-like requests that carry byte-lane write strobes and replicated write data from the load/store unit. It commits writes lane-by-lane into a word-addressed backing store and returns full 32-bit read words after a configurable latency. Load-side byte/halfword extraction stays in the CPU. It is the data RAM model behind the core in simulation and on FPGA.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_array.sv | 29 ++
 rtl/data_sram_responder.sv | 119 +++++++++++
 tb/tb_data_sram_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, state enum, request payload and strobe rule for the data SRAM responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dreq_t;

    // Strobe a well-formed store of this size/offset must carry; 0 for an illegal size.
    function automatic logic [3:0] legal_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 synchronous RAM with byte-lane write enables and registered read.
module dmem_array #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read returns the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// CPU data-port responder: accepts one SRAM-like request at a time and answers after LATENCY cycles.
module data_sram_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        data_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dreq_t       req_q, req_d, live, cur;
    logic        addr_ok_q, data_ok_q, err_q, rsel_q;
    logic        accept, go_resp, err_c;
    logic [29:0] widx;
    logic [3:0]  we;
    logic [31:0] mem_rdata;

    assign accept = data_req & addr_ok_q;

    always_comb begin
        live.wr    = data_wr;
        live.size  = data_size;
        live.addr  = data_addr;
        live.wstrb = data_wstrb;
        live.wdata = data_wdata;
    end

    // Next-state: accept in IDLE/RESP, count down in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    req_d   = live;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the accept edge itself, before the latch is loaded.
    assign cur     = (state_q == WAIT) ? req_q : live;
    assign go_resp = (state_d == RESP);
    assign widx    = 30'((cur.addr - BASE_ADDR) >> 2);

    always_comb begin
        err_c = 1'b0;
        if (cur.size == 2'd3)                                  err_c = 1'b1;
        if (cur.size == SZ_HALF && cur.addr[0])                err_c = 1'b1;
        if (cur.size == SZ_WORD && cur.addr[1:0] != 2'b00)     err_c = 1'b1;
        if (cur.addr < BASE_ADDR || widx >= 30'(DEPTH))        err_c = 1'b1;
        if (cur.wr && cur.wstrb != legal_wstrb(cur.size, cur.addr[1:0])) err_c = 1'b1;
    end

    assign we = (go_resp && cur.wr && !err_c && !rst) ? cur.wstrb : 4'b0000;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .en_i    (go_resp & ~rst),
        .we_i    (we),
        .addr_i  (widx[AW-1:0]),
        .wdata_i (cur.wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            req_q     <= '0;
            addr_ok_q <= 1'b1;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            rsel_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            addr_ok_q <= (state_d != WAIT);
            data_ok_q <= go_resp;
            err_q     <= go_resp & err_c;
            rsel_q    <= go_resp & ~cur.wr & ~err_c;
        end
    end

    assign data_addr_ok = addr_ok_q;
    assign data_data_ok = data_ok_q;
    assign data_err     = err_q;
    assign data_rdata   = rsel_q ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench: three responders (LATENCY 1/3/4) against a word-array reference model.
module tb_data_sram_responder;

    localparam int unsigned DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic        req     [3];
    logic        wr      [3];
    logic [1:0]  size    [3];
    logic [31:0] addr    [3];
    logic [3:0]  wstrb   [3];
    logic [31:0] wdata   [3];
    logic        addr_ok [3];
    logic        data_ok [3];
    logic [31:0] rdata   [3];
    logic        err     [3];

    int errors = 0;
    int checks = 0;
    logic [31:0] mdl [int];

    data_sram_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
        .clk(clk), .rst(rst), .data_req(req[0]), .data_wr(wr[0]), .data_size(size[0]),
        .data_addr(addr[0]), .data_wstrb(wstrb[0]), .data_wdata(wdata[0]),
        .data_addr_ok(addr_ok[0]), .data_data_ok(data_ok[0]), .data_rdata(rdata[0]), .data_err(err[0]));

    data_sram_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
        .clk(clk), .rst(rst), .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
        .data_addr(addr[1]), .data_wstrb(wstrb[1]), .data_wdata(wdata[1]),
        .data_addr_ok(addr_ok[1]), .data_data_ok(data_ok[1]), .data_rdata(rdata[1]), .data_err(err[1]));

    data_sram_responder #(.DEPTH(DEPTH), .LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (
        .clk(clk), .rst(rst), .data_req(req[2]), .data_wr(wr[2]), .data_size(size[2]),
        .data_addr(addr[2]), .data_wstrb(wstrb[2]), .data_wdata(wdata[2]),
        .data_addr_ok(addr_ok[2]), .data_data_ok(data_ok[2]), .data_rdata(rdata[2]), .data_err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 3 : 4;
    endfunction

    function automatic logic [3:0] exp_strobe(input logic [1:0] sz, input int unsigned off);
        case (sz)
            2'd0:    return 4'(1 << off);
            2'd1:    return (off == 0) ? 4'b0011 : 4'b1100;
            2'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit model_err(input bit w, input logic [1:0] sz, input logic [31:0] a,
                                     input logic [3:0] st);
        int unsigned off;
        off = a % 4;
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && (off % 2) != 0) return 1'b1;
        if (sz == 2'd2 && off != 0) return 1'b1;
        if ((a / 4) >= DEPTH) return 1'b1;
        if (w && st != exp_strobe(sz, off)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_store(input int i, input logic [31:0] a, input logic [3:0] st,
                               input logic [31:0] wd);
        int key;
        logic [31:0] word;
        key  = i * int'(DEPTH) + int'(a / 4);
        word = mdl.exists(key) ? mdl[key] : 32'h0;
        for (int l = 0; l < 4; l++) if (st[l]) word[8*l +: 8] = wd[8*l +: 8];
        mdl[key] = word;
    endtask

    task automatic drive(input int i, input bit r, input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd);
        req[i] = r; wr[i] = w; size[i] = sz; addr[i] = a; wstrb[i] = st; wdata[i] = wd;
    endtask

    // Entered and left at a negedge: issue one request and check its response.
    task automatic xact(input int i, input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] wd, input string tag);
        bit          e_err, ok, lowok;
        logic [31:0] e_rd;
        int          n;
        e_err = model_err(w, sz, a, st);
        e_rd  = 32'h0;
        if (!e_err && !w) e_rd = mdl[i * int'(DEPTH) + int'(a / 4)];
        if (!e_err && w) model_store(i, a, st, wd);
        drive(i, 1'b1, w, sz, a, st, wd);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (addr_ok[i]) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            chk({tag, ".accept_timeout"}, 32'd0, 32'd1);
            req[i] = 1'b0;
            return;
        end
        n = 0;
        lowok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) req[i] = 1'b0;
            n++;
            if (data_ok[i]) break;
            if (addr_ok[i]) lowok = 1'b0;
        end
        chk({tag, ".lat"}, 32'(n), 32'(lat_of(i)));
        chk({tag, ".err"}, 32'(err[i]), 32'(e_err));
        chk({tag, ".rdata"}, rdata[i], e_rd);
        chk({tag, ".aok_resp"}, 32'(addr_ok[i]), 32'd1);
        if (lat_of(i) > 1) chk({tag, ".aok_wait"}, 32'(lowok), 32'd1);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(data_ok[i]), 32'd0);
    endtask

    initial begin
        int          n, nd;
        bit          lowok, w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [3:0]  st;

        rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d.aok", i), 32'(addr_ok[i]), 32'd1);
            chk($sformatf("reset%0d.dok", i), 32'(data_ok[i]), 32'd0);
            chk($sformatf("reset%0d.rdata", i), rdata[i], 32'h0);
            chk($sformatf("reset%0d.err", i), 32'(err[i]), 32'd0);
        end

        // LATENCY=1 directed word, merge and error cases
        xact(0, 1'b1, 2'd2, 32'h10, 4'b1111, 32'hDEADBEEF, "sw10");
        xact(0, 1'b0, 2'd2, 32'h10, 4'b0000, 32'h0, "lw10");
        xact(0, 1'b1, 2'd2, 32'h20, 4'b1111, 32'h11223344, "sw20");
        xact(0, 1'b1, 2'd0, 32'h23, 4'b1000, 32'hAAAAAAAA, "sb23");
        xact(0, 1'b0, 2'd2, 32'h20, 4'b0000, 32'h0, "lw20a");
        chk("merge_byte", mdl[32'h20 / 4], 32'hAA223344);
        xact(0, 1'b1, 2'd1, 32'h20, 4'b0011, 32'h55665566, "sh20");
        xact(0, 1'b0, 2'd2, 32'h20, 4'b0000, 32'h0, "lw20b");
        chk("merge_half", mdl[32'h20 / 4], 32'hAA225566);
        xact(0, 1'b0, 2'd2, 32'h22, 4'b0000, 32'h0, "lw22_misal");
        xact(0, 1'b1, 2'd1, 32'h21, 4'b0011, 32'hFFFFFFFF, "sh21_misal");
        xact(0, 1'b0, 2'd2, 32'h20, 4'b0000, 32'h0, "lw20c");
        xact(0, 1'b1, 2'd2, 32'h30, 4'b1111, 32'hCAFEF00D, "sw30");
        xact(0, 1'b1, 2'd2, 32'h30, 4'b0011, 32'h12345678, "sw30_badstrb");
        xact(0, 1'b0, 2'd2, 32'h30, 4'b0000, 32'h0, "lw30");
        xact(0, 1'b0, 2'd2, DEPTH * 4, 4'b0000, 32'h0, "lw_oob");
        xact(0, 1'b0, 2'd3, 32'h10, 4'b0000, 32'h0, "size3");
        xact(0, 1'b0, 2'd0, 32'h13, 4'b0000, 32'h0, "lb13");

        // LATENCY=3 back-to-back: store at t, queued load accepted in the RESP cycle
        model_store(1, 32'h40, 4'b1111, 32'h1);
        drive(1, 1'b1, 1'b1, 2'd2, 32'h40, 4'b1111, 32'h1);
        chk("b2b.aok_idle", 32'(addr_ok[1]), 32'd1);
        n = 0;
        lowok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) drive(1, 1'b1, 1'b0, 2'd2, 32'h40, 4'b0000, 32'h0);
            n++;
            if (data_ok[1]) break;
            if (addr_ok[1]) lowok = 1'b0;
        end
        chk("b2b.st_lat", 32'(n), 32'd3);
        chk("b2b.st_aok_wait", 32'(lowok), 32'd1);
        chk("b2b.st_aok_resp", 32'(addr_ok[1]), 32'd1);
        chk("b2b.st_rdata", rdata[1], 32'h0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) req[1] = 1'b0;
            n++;
            if (data_ok[1]) break;
        end
        chk("b2b.ld_lat", 32'(n), 32'd3);
        chk("b2b.ld_rdata", rdata[1], 32'h1);
        chk("b2b.ld_err", 32'(err[1]), 32'd0);
        @(negedge clk);

        // LATENCY=4 reset during a pending store
        xact(2, 1'b1, 2'd2, 32'h50, 4'b1111, 32'h0, "sw50_init");
        drive(2, 1'b1, 1'b1, 2'd2, 32'h50, 4'b1111, 32'h77);
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.aok", 32'(addr_ok[2]), 32'd1);
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (data_ok[2]) nd++;
        end
        chk("rstmid.no_dok", 32'(nd), 32'd0);
        xact(2, 1'b0, 2'd2, 32'h50, 4'b0000, 32'h0, "lw50");

        // Randomized traffic on LATENCY 1 and 3 over a pre-written window
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++)
                xact(i, 1'b1, 2'd2, 32'h100 + 32'(4 * k), 4'b1111, $urandom, "rnd_init");
            for (int k = 0; k < 30; k++) begin
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = DEPTH * 4 + 32'($urandom_range(0, 15));
                else                           a = 32'h100 + 32'($urandom_range(0, 63));
                st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : exp_strobe(sz, a % 4);
                xact(i, w, sz, a, st, $urandom, $sformatf("rnd%0d_%0d", i, k));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
